mc_ctrl_unit: RTL and testbench

- Sequential half of the multicycle MIPS controller.
- Holds the FSM state register and drives the state back to the combinational next-state logic (state_in).
- Registers that logic's state_next, subject to a memory-wait handshake and an illegal-opcode check.
- Decodes the registered state plus opcode/funct into the datapath control strobes, and keeps cycle and retired-instruction counters.

---
 rtl/mc_ctrl_unit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit -- sequential half of the multicycle MIPS controller.
//
// Holds the FSM state register and hands the current state to the external
// combinational next-state logic, which returns state_next. That value is
// registered subject to a memory-wait hold and an illegal-opcode/funct check.
// The registered state, together with opcode/funct/zero, is decoded into the
// datapath strobes. Cycle and retired-instruction counters are also kept here.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   state_next [3:0]  next state proposed by the next-state logic
//   opcode, funct     IR[31:26], IR[5:0]
//   zero              ALU zero flag (beq decision)
//   mem_ready         memory access completes this cycle
//   state [3:0]       current state, fed to the next-state logic
//   pc_wr .. pc_src   datapath control strobes (all 0 until run is set)
//   illegal           one-cycle pulse on an unsupported opcode/funct/state
//   instr_done        one-cycle pulse when an instruction retires
//   cycle_cnt         cycles counted since the controller started running
//   instr_cnt         retired instructions
module mc_ctrl_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       state_next,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             iord,
    output logic             byte_en,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       ext_op,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_MA     = 4'd2,
        S_MR     = 4'd3,
        S_MEMWB  = 4'd4,
        S_MW     = 4'd5,
        S_EXE    = 4'd6,
        S_WB     = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    state_t cur_state;
    state_t next_d;
    logic   run;
    logic   hold;
    logic   op_ok;
    logic   fn_ok;
    logic   ill_d;
    logic   retire_d;

    assign state = cur_state;

    // Supported instruction set: anything else decoded in ID is flagged.
    always_comb begin
        op_ok = 1'b0;
        case (opcode)
            OP_RTYPE, OP_ORI, OP_LUI, OP_ADDIU, OP_ADDI, OP_BEQ,
            OP_SW, OP_LW, OP_SB, OP_LB, OP_J, OP_JAL: op_ok = 1'b1;
            default:                                  op_ok = 1'b0;
        endcase
        fn_ok = 1'b0;
        case (funct)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_JR, FN_JALR: fn_ok = 1'b1;
            default:                                                 fn_ok = 1'b0;
        endcase
    end

    // State update: memory wait holds first, then the illegal checks,
    // otherwise accept the next-state logic's proposal. An illegal exit
    // restarts fetch without counting as a retirement.
    always_comb begin
        next_d   = cur_state;
        ill_d    = 1'b0;
        hold     = ((cur_state == S_IF) || (cur_state == S_MR) || (cur_state == S_MW))
                   && !mem_ready;
        if (hold) begin
            next_d = cur_state;
        end else if ((cur_state == S_ID) && !op_ok) begin
            ill_d = 1'b1;
        end else if ((cur_state == S_ID) && (opcode == OP_RTYPE) && !fn_ok) begin
            ill_d = 1'b1;
        end else if (state_next > 4'd9) begin
            ill_d = 1'b1;
        end else begin
            next_d = state_t'(state_next);
        end
        if (ill_d) begin
            next_d = S_IF;
        end
        retire_d = !ill_d && !hold && (next_d == S_IF) &&
                   ((cur_state == S_MEMWB) || (cur_state == S_MW) || (cur_state == S_WB) ||
                    (cur_state == S_BRANCH) || (cur_state == S_JUMP));
    end

    // run gates everything for the first cycle after reset release so the
    // first fetch strobes appear one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            cur_state  <= S_IF;
            illegal    <= 1'b0;
            instr_done <= 1'b0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            cur_state  <= next_d;
            illegal    <= ill_d;
            instr_done <= retire_d;
            cycle_cnt  <= cycle_cnt + CNT_W'(1);
            if (retire_d) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    // Moore decode of the datapath strobes; IF's write enables follow
    // mem_ready so PC/IR only load when the fetch actually completes.
    always_comb begin
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        iord      = 1'b0;
        byte_en   = 1'b0;
        reg_wr    = 1'b0;
        reg_dst   = 2'b00;
        wb_sel    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        ext_op    = 2'b00;
        alu_op    = 2'b00;
        pc_src    = 2'b00;
        if (run) begin
            case (cur_state)
                S_IF: begin
                    mem_rd    = 1'b1;
                    alu_src_b = 2'b01;
                    ir_wr     = mem_ready;
                    pc_wr     = mem_ready;
                end
                S_ID: begin
                    alu_src_b = 2'b11;
                    ext_op    = 2'b01;
                end
                S_MA: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ext_op    = 2'b01;
                end
                S_MR: begin
                    mem_rd  = 1'b1;
                    iord    = 1'b1;
                    byte_en = (opcode == OP_LB);
                end
                S_MEMWB: begin
                    reg_wr  = 1'b1;
                    wb_sel  = 2'b01;
                    byte_en = (opcode == OP_LB);
                end
                S_MW: begin
                    mem_wr  = 1'b1;
                    iord    = 1'b1;
                    byte_en = (opcode == OP_SB);
                end
                S_EXE: begin
                    case (opcode)
                        OP_RTYPE: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b10;
                        end
                        OP_ORI: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            ext_op    = 2'b00;
                            alu_op    = 2'b11;
                        end
                        OP_LUI: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            ext_op    = 2'b10;
                        end
                        OP_ADDI, OP_ADDIU: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            ext_op    = 2'b01;
                        end
                        default: begin
                        end
                    endcase
                end
                S_WB: begin
                    reg_wr  = 1'b1;
                    reg_dst = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_wr     = zero;
                end
                S_JUMP: begin
                    if (opcode == OP_J) begin
                        pc_src = 2'b10;
                        pc_wr  = 1'b1;
                    end else if (opcode == OP_JAL) begin
                        pc_src  = 2'b10;
                        pc_wr   = 1'b1;
                        reg_wr  = 1'b1;
                        reg_dst = 2'b10;
                        wb_sel  = 2'b10;
                    end else if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
                        pc_src = 2'b11;
                        pc_wr  = 1'b1;
                    end else if ((opcode == OP_RTYPE) && (funct == FN_JALR)) begin
                        pc_src  = 2'b11;
                        pc_wr   = 1'b1;
                        reg_wr  = 1'b1;
                        reg_dst = 2'b01;
                        wb_sel  = 2'b10;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit -- self-checking bench for mc_ctrl_unit.
//
// The bench plays the role of the next-state logic and of memory. A
// behavioural model (state number, run flag, counters kept modulo 2^CNT_W)
// predicts every output each cycle. Directed instruction runs come first,
// then a long randomized run that includes bad opcodes, bad functs, bad
// next states and memory stalls, then a reset dropped while in MW.
module tb_mc_ctrl_unit;

    localparam int CNT_W = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       state_next;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic [3:0]       state;
    logic             pc_wr, ir_wr, mem_rd, mem_wr, iord, byte_en, reg_wr;
    logic [1:0]       reg_dst, wb_sel, alu_src_b, ext_op, alu_op, pc_src;
    logic             alu_src_a;
    logic             illegal, instr_done;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    mc_ctrl_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state_next (state_next),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .state      (state),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .byte_en    (byte_en),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .wb_sel     (wb_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .instr_done (instr_done),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    logic [5:0] legal_ops [12] = '{6'b000000, 6'b001101, 6'b001111, 6'b001001,
                                   6'b001000, 6'b000100, 6'b101011, 6'b100011,
                                   6'b101000, 6'b100000, 6'b000010, 6'b000011};
    logic [5:0] legal_fns [7]  = '{6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                   6'b101010, 6'b001000, 6'b001001};

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_run;
    int m_state;
    bit m_ill;
    bit m_done;
    int m_cyc;
    int m_icnt;

    // Single comparison point: counts and reports each check.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit op_legal(logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit fn_legal(logic [5:0] fn);
        foreach (legal_fns[i]) if (legal_fns[i] == fn) return 1'b1;
        return 1'b0;
    endfunction

    // Well-behaved next-state logic for a given instruction.
    function automatic logic [3:0] next_of(int st, logic [5:0] op, logic [5:0] fn);
        case (st)
            0: return 4'd1;
            1: begin
                if (op == 6'b100011 || op == 6'b100000 || op == 6'b101011 || op == 6'b101000)
                    return 4'd2;
                if (op == 6'b000000) return (fn == 6'b001000 || fn == 6'b001001) ? 4'd9 : 4'd6;
                if (op == 6'b001101 || op == 6'b001111 || op == 6'b001000 || op == 6'b001001)
                    return 4'd6;
                if (op == 6'b000100) return 4'd8;
                if (op == 6'b000010 || op == 6'b000011) return 4'd9;
                return 4'd0;
            end
            2: return (op == 6'b100011 || op == 6'b100000) ? 4'd3 : 4'd5;
            3: return 4'd4;
            6: return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    // Expected strobe bundle for a state and instruction, in the order
    // {pc_wr, ir_wr, mem_rd, mem_wr, iord, byte_en, reg_wr, reg_dst,
    //  wb_sel, alu_src_a, alu_src_b, ext_op, alu_op, pc_src}.
    function automatic logic [19:0] exp_ctrl(int st, logic [5:0] op, logic [5:0] fn,
                                             logic z, logic mr, bit run);
        logic pcw = 0, irw = 0, mrd = 0, mwr = 0, io = 0, be = 0, rw = 0, sa = 0;
        logic [1:0] rd = 0, wb = 0, sb = 0, eo = 0, ao = 0, ps = 0;
        bit is_r = (op == 6'b000000);
        if (run) begin
            case (st)
                0: begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
                1: begin sb = 2'b11; eo = 2'b01; end
                2: begin sa = 1; sb = 2'b10; eo = 2'b01; end
                3: begin mrd = 1; io = 1; be = (op == 6'b100000); end
                4: begin rw = 1; wb = 2'b01; be = (op == 6'b100000); end
                5: begin mwr = 1; io = 1; be = (op == 6'b101000); end
                6: begin
                    if (is_r) begin sa = 1; ao = 2'b10; end
                    else if (op == 6'b001101) begin sa = 1; sb = 2'b10; ao = 2'b11; end
                    else if (op == 6'b001111) begin sa = 1; sb = 2'b10; eo = 2'b10; end
                    else if (op == 6'b001000 || op == 6'b001001) begin sa = 1; sb = 2'b10; eo = 2'b01; end
                end
                7: begin rw = 1; rd = is_r ? 2'b01 : 2'b00; end
                8: begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = z; end
                9: begin
                    if (op == 6'b000010 || op == 6'b000011) begin ps = 2'b10; pcw = 1; end
                    if (op == 6'b000011) begin rw = 1; rd = 2'b10; wb = 2'b10; end
                    if (is_r && (fn == 6'b001000 || fn == 6'b001001)) begin ps = 2'b11; pcw = 1; end
                    if (is_r && fn == 6'b001001) begin rw = 1; rd = 2'b01; wb = 2'b10; end
                end
                default: begin end
            endcase
        end
        return {pcw, irw, mrd, mwr, io, be, rw, rd, wb, sa, sb, eo, ao, ps};
    endfunction

    task automatic model_reset();
        m_run = 0; m_state = 0; m_ill = 0; m_done = 0; m_cyc = 0; m_icnt = 0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic [3:0] sn, input logic [5:0] op,
                              input logic [5:0] fn, input logic mr);
        bit hold, ill, done;
        int ns;
        if (!m_run) begin
            m_run = 1;
            return;
        end
        hold = (m_state == 0 || m_state == 3 || m_state == 5) && !mr;
        ill  = 0;
        ns   = m_state;
        if (!hold) begin
            if (m_state == 1 && !op_legal(op)) ill = 1;
            else if (m_state == 1 && op == 6'b000000 && !fn_legal(fn)) ill = 1;
            else if (int'(sn) > 9) ill = 1;
            else ns = int'(sn);
            if (ill) ns = 0;
        end
        done = !hold && !ill && ns == 0 &&
               (m_state == 4 || m_state == 5 || m_state == 7 || m_state == 8 || m_state == 9);
        m_cyc = (m_cyc + 1) % CNT_MOD;
        if (done) m_icnt = (m_icnt + 1) % CNT_MOD;
        m_state = ns;
        m_ill   = ill;
        m_done  = done;
    endtask

    // Drive one cycle of inputs, check every output, then advance the model.
    task automatic applyStimulus(input logic [3:0] sn, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z, input logic mr);
        @(negedge clk);
        state_next = sn; opcode = op; funct = fn; zero = z; mem_ready = mr;
        #1;
        checkOutput("state", 64'(state), 64'(m_state));
        checkOutput("ctrl", 64'({pc_wr, ir_wr, mem_rd, mem_wr, iord, byte_en, reg_wr, reg_dst,
                                 wb_sel, alu_src_a, alu_src_b, ext_op, alu_op, pc_src}),
                    64'(exp_ctrl(m_state, op, fn, z, mr, m_run)));
        checkOutput("illegal", 64'(illegal), 64'(m_ill));
        checkOutput("instr_done", 64'(instr_done), 64'(m_done));
        checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
        checkOutput("instr_cnt", 64'(instr_cnt), 64'(m_icnt));
        model_step(sn, op, fn, mr);
    endtask

    // Run one instruction from IF back to IF, stalling MR/MW for mr_waits cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int mr_waits);
        int waits = mr_waits;
        int n = 0;
        logic mr;
        do begin
            mr = 1'b1;
            if ((m_state == 3 || m_state == 5) && waits > 0) begin
                mr = 1'b0;
                waits--;
            end
            applyStimulus(next_of(m_state, op, fn), op, fn, z, mr);
            n++;
        end while (m_state != 0 && n < 40);
        if (m_state != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL instr_timeout: state %0d after %0d cycles, required 0", m_state, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        state_next = 4'd0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [3:0] sn;
        int n;

        do_reset();
        // Cycle 0: everything quiet, then first fetch with mem_ready high.
        applyStimulus(4'd1, 6'd0, 6'd0, 1'b0, 1'b1);

        run_instr(6'b100011, 6'd0, 1'b0, 3);       // lw with three MR stalls
        run_instr(6'b000100, 6'd0, 1'b1, 0);       // beq taken
        run_instr(6'b000100, 6'd0, 1'b0, 0);       // beq not taken
        run_instr(6'b000011, 6'd0, 1'b0, 0);       // jal
        run_instr(6'b111111, 6'd0, 1'b0, 0);       // illegal opcode
        run_instr(6'b000000, 6'b111111, 1'b0, 0);  // illegal funct
        run_instr(6'b000000, 6'b100001, 1'b0, 0);  // addu
        run_instr(6'b000000, 6'b001000, 1'b0, 0);  // jr
        run_instr(6'b000000, 6'b001001, 1'b0, 0);  // jalr
        run_instr(6'b001101, 6'd0, 1'b0, 0);       // ori
        run_instr(6'b001111, 6'd0, 1'b0, 0);       // lui
        run_instr(6'b001000, 6'd0, 1'b0, 0);       // addi
        run_instr(6'b100000, 6'd0, 1'b0, 1);       // lb
        run_instr(6'b101000, 6'd0, 1'b0, 2);       // sb
        run_instr(6'b000010, 6'd0, 1'b0, 0);       // j

        // Randomized run, long enough to wrap both 8-bit counters.
        op = 6'd0;
        fn = 6'b100001;
        for (int i = 0; i < 1800; i++) begin
            if (m_state == 0) begin
                if ($urandom_range(0, 9) == 0) op = 6'($urandom);
                else op = legal_ops[$urandom_range(0, 11)];
                if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
                else fn = legal_fns[$urandom_range(0, 6)];
            end
            sn = next_of(m_state, op, fn);
            if ($urandom_range(0, 29) == 0) sn = 4'($urandom_range(10, 15));
            applyStimulus(sn, op, fn, 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Reset dropped asynchronously while a store is waiting in MW.
        while (m_state != 0) applyStimulus(4'd0, 6'b101011, 6'd0, 1'b0, 1'b1);
        n = 0;
        while (m_state != 5 && n < 20) begin
            applyStimulus(next_of(m_state, 6'b101011, 6'd0), 6'b101011, 6'd0, 1'b0,
                          (m_state != 5));
            n++;
        end
        applyStimulus(4'd0, 6'b101011, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_mem_wr", 64'(mem_wr), 64'd0);
        checkOutput("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        checkOutput("rst_instr_cnt", 64'(instr_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
